// File: rtl/viola_pkg.sv
// Shared fetch-front-end definitions: architectural widths, reset PC and the
// request FSM state encoding.
package viola_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;
  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO holding {pc, inst} pairs; flush wins over push and pop.
module fetch_buffer
  import viola_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * XLEN,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: sequential PC generation, single-outstanding memory requests,
// prefetch buffering and redirect handling in front of the decoder.
module instr_fetch
  import viola_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iq_full,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  localparam int CW  = $clog2(BUF_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_addr;
  logic [CW-1:0]     buf_count;
  logic [CW1-1:0]    credits;
  logic [2*XLEN-1:0] buf_rdata;
  logic              buf_full;
  logic              buf_empty;
  logic              outstanding;
  logic              accept;
  logic              push;
  logic              pop;

  assign outstanding = (state == REQ) || (state == WAIT);
  assign credits     = CW1'(BUF_DEPTH) - {1'b0, buf_count} - CW1'(outstanding);
  assign accept      = (state == REQ) && mem_ready;
  assign push        = (state == WAIT) && mem_rvalid && !redirect_valid && !buf_full;
  assign pop         = !buf_empty && !iq_full && !redirect_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // A redirect that coincides with acceptance still owes a response, hence DROP.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (!redirect_valid && credits != '0) state_nx = REQ;
      REQ: begin
        if (redirect_valid)  state_nx = mem_ready ? DROP : IDLE;
        else if (mem_ready)  state_nx = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)          state_nx = IDLE;
        else if (redirect_valid) state_nx = DROP;
      end
      DROP: if (mem_rvalid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state == REQ);
    mem_addr = req_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= '0;
    end else begin
      if (redirect_valid) fetch_pc <= align_pc(redirect_pc);
      else if (accept)    fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
      if (state == IDLE && state_nx == REQ) req_addr <= fetch_pc;
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({req_addr, mem_rdata}),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  // Delivery stage: outputs hold their last word when nothing is popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc_out     <= '0;
    end else if (pop) begin
      inst_valid <= 1'b1;
      pc_out     <= buf_rdata[2*XLEN-1:XLEN];
      inst_out   <= buf_rdata[XLEN-1:0];
    end else begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, checked
// against a sequential-stream model of requests and deliveries.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        iq_full = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;

  instr_fetch #(.RESET_PC(32'h0), .BUF_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .iq_full        (iq_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ready      (mem_ready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc, exp_req;
  bit          pend;
  logic [31:0] pend_addr;
  int          pend_cnt;
  int          lat_fix = 1;
  int          n_deliv = 0, n_accept = 0, n_resp = 0;
  logic [31:0] last_accept_addr = '0, last_deliv_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: check what the edge produced, then advance the memory model.
  task automatic step();
    logic pre_req, pre_ready, pre_redir, pre_rv, pre_rst;
    logic [31:0] pre_addr, pre_target;
    pre_req    = mem_req;
    pre_ready  = mem_ready;
    pre_redir  = redirect_valid;
    pre_rv     = mem_rvalid;
    pre_rst    = rst;
    pre_addr   = mem_addr;
    pre_target = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    if (pre_req && pre_ready) begin
      chk("one_outstanding", pend, 1'b0);
      chk("req_addr", pre_addr, exp_req);
      exp_req = exp_req + 32'd4;
      n_accept++;
      last_accept_addr = pre_addr;
    end
    if (pre_req && !pre_ready && !pre_redir && pre_rst && rst) begin
      chk("req_hold", mem_req, 1'b1);
      chk("addr_hold", mem_addr, pre_addr);
    end
    if (pre_redir) begin
      chk("redirect_kill", inst_valid, 1'b0);
      exp_pc  = pre_target;
      exp_req = pre_target;
    end else if (inst_valid) begin
      chk("pc_seq", pc_out, exp_pc);
      chk("inst_data", inst_out, mem_word(pc_out));
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
      last_deliv_pc = pc_out;
    end
    if (pre_rv) begin
      pend = 1'b0;
      n_resp++;
    end else if (pend) begin
      pend_cnt--;
    end
    if (pre_req && pre_ready) begin
      pend      = 1'b1;
      pend_addr = pre_addr;
      pend_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1));
    end
    mem_rvalid     = pend && (pend_cnt == 1);
    mem_rdata      = mem_rvalid ? mem_word(pend_addr) : $urandom;
    redirect_valid = 1'b0;
  endtask

  task automatic hard_reset(input bit check_outputs);
    rst            = 1'b0;
    pend           = 1'b0;
    mem_rvalid     = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check_outputs) begin
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
    end
    exp_pc  = 32'h0;
    exp_req = 32'h0;
    rst     = 1'b1;
  endtask

  task automatic rnd_drive();
    mem_ready = ($urandom_range(99, 0) < 70);
    iq_full   = ($urandom_range(99, 0) < 30);
    if ($urandom_range(99, 0) < 3) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
    end
  endtask

  initial begin
    int a0, d0, r0;
    logic [31:0] held;

    // Reset state
    hard_reset(1'b1);

    // Streaming with an always-ready memory
    lat_fix = 1; mem_ready = 1'b1; iq_full = 1'b0; n_deliv = 0;
    repeat (40) step();
    chk("t1_stream_count", n_deliv >= 10, 1'b1);

    // Back-pressure fills the buffer, then a burst drains it
    hard_reset(1'b0);
    iq_full = 1'b1; mem_ready = 1'b1; n_accept = 0;
    repeat (20) step();
    chk("t2_accepts", n_accept, 4);
    chk("t2_req_off", mem_req, 1'b0);
    iq_full = 1'b0; n_deliv = 0;
    repeat (4) step();
    chk("t2_burst", n_deliv, 4);
    chk("t2_last_pc", last_deliv_pc, 32'hC);
    for (int i = 0; i < 20 && n_accept < 5; i++) step();
    chk("t2_resume_seen", n_accept, 5);
    chk("t2_resume_addr", last_accept_addr, 32'h10);

    // Memory stalls: request and address held
    mem_ready = 1'b0;
    for (int i = 0; i < 20 && !mem_req; i++) step();
    chk("t3_req_seen", mem_req, 1'b1);
    held = mem_addr;
    repeat (5) begin
      step();
      chk("t3_req", mem_req, 1'b1);
      chk("t3_addr", mem_addr, held);
    end
    mem_ready = 1'b1;

    // Redirect while a response is owed
    lat_fix = 3; a0 = n_accept;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    chk("t4_accept_seen", n_accept > a0, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0103;
    step();
    lat_fix = 1; a0 = n_accept; d0 = n_deliv;
    for (int i = 0; i < 30 && n_accept == a0; i++) step();
    chk("t4_new_addr", last_accept_addr, 32'h8000_0100);
    for (int i = 0; i < 30 && n_deliv == d0; i++) step();
    chk("t4_deliv_seen", n_deliv > d0, 1'b1);
    chk("t4_first_pc", last_deliv_pc, 32'h8000_0100);

    // Redirect colliding with a pop and a response
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000; iq_full = 1'b1;
    step();
    r0 = n_resp;
    for (int i = 0; i < 40 && n_resp < r0 + 2; i++) step();
    chk("t5_two_buffered", n_resp >= r0 + 2, 1'b1);
    lat_fix = 2; a0 = n_accept;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    for (int i = 0; i < 5 && !mem_rvalid; i++) step();
    chk("t5_rvalid_ready", mem_rvalid, 1'b1);
    iq_full = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_4000;
    step();
    chk("t5_valid_low", inst_valid, 1'b0);
    lat_fix = 1; d0 = n_deliv;
    for (int i = 0; i < 30 && n_deliv == d0; i++) step();
    chk("t5_first_pc", last_deliv_pc, 32'h0000_4000);

    // Asynchronous reset in the middle of an outstanding request
    lat_fix = 3; a0 = n_accept;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    step();
    #3 rst = 1'b0;
    #1;
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_inst_valid", inst_valid, 1'b0);
    chk("t6_inst_out", inst_out, 32'h0);
    chk("t6_pc_out", pc_out, 32'h0);
    exp_pc = 32'h0; exp_req = 32'h0;
    step();
    rst = 1'b1;
    step();
    lat_fix = 1; a0 = n_accept; d0 = n_deliv;
    for (int i = 0; i < 20 && n_accept == a0; i++) step();
    chk("t6_first_addr", last_accept_addr, 32'h0);
    for (int i = 0; i < 20 && n_deliv == d0; i++) step();
    chk("t6_first_pc", last_deliv_pc, 32'h0);

    // Randomized traffic
    lat_fix = 0; d0 = n_deliv;
    repeat (600) begin
      rnd_drive();
      step();
    end
    iq_full = 1'b0; mem_ready = 1'b1;
    repeat (30) step();
    chk("rand_progress", (n_deliv - d0) > 30, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
